// File: rtl/binary_to_bcd_seq_pkg.sv
// ---------------------------------------------------------------------------
// bcd_defs : shared constants and FSM encoding for binary_to_bcd_seq
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bcd_defs;

   localparam int         DIGIT_W    = 4;
   localparam logic [3:0] BLANK_CODE = 4'hF;
   localparam logic [3:0] SAT_DIGIT  = 4'h9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/binary_to_bcd_seq_if.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_seq_if : start/busy/done handshake and result bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface binary_to_bcd_seq_if
   import bcd_defs::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);

   logic                        start;
   logic [WIDTH-1:0]            data;
   logic                        busy;
   logic                        done;
   logic [DIGIT_W*DIGITS-1:0]   bcd;
   logic                        overflow;

   modport master (
      output start, data,
      input  busy, done, bcd, overflow
   );

   modport slave (
      input  start, data,
      output busy, done, bcd, overflow
   );

endinterface

`default_nettype wire

// File: rtl/binary_to_bcd_seq_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3 : double-dabble digit correction (digit >= 5 ? digit + 3 : digit)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_add3
   import bcd_defs::*;
(
   input  wire logic [DIGIT_W-1:0] digit_i,
   output logic      [DIGIT_W-1:0] digit_o
);

   assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

`default_nettype wire

// File: rtl/binary_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_seq : sequential shift-and-add-3 converter, one bit per clock,
// saturating overflow. Optional leading-zero blanking via BCD_BLANK_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module binary_to_bcd_seq
   import bcd_defs::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
)(
   input  wire logic             clock,
   input  wire logic             reset,
   binary_to_bcd_seq_if.slave    bus
);

   localparam int                 BCD_W    = DIGIT_W * DIGITS;
   localparam int                 CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

   state_t                 state_q;
   logic [WIDTH-1:0]       sreg_q;
   logic [BCD_W-1:0]       digits_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   sticky_q;
   logic                   busy_q;
   logic                   done_q;
   logic [BCD_W-1:0]       bcd_q;
   logic                   ovf_q;

   logic [BCD_W-1:0]       adj_w;
   logic [BCD_W+WIDTH:0]   shifted_w;
   logic [BCD_W-1:0]       digits_d;
   logic [WIDTH-1:0]       sreg_d;
   logic                   sticky_d;
   logic [BCD_W-1:0]       result_d;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .digit_i (digits_q[g*DIGIT_W +: DIGIT_W]),
         .digit_o (adj_w[g*DIGIT_W +: DIGIT_W])
      );
   end

   // MSB of the shifted word is the bit leaving the top digit
   assign shifted_w = {adj_w, sreg_q, 1'b0};
   assign digits_d  = shifted_w[BCD_W+WIDTH-1:WIDTH];
   assign sreg_d    = shifted_w[WIDTH-1:0];
   assign sticky_d  = sticky_q | shifted_w[BCD_W+WIDTH];

`ifdef BCD_BLANK_EN
   logic leading_w;
`endif

   always_comb begin
      result_d = digits_d;
`ifdef BCD_BLANK_EN
      leading_w = 1'b1;
`endif
      if (sticky_d) begin
         result_d = {DIGITS{SAT_DIGIT}};
      end else begin
`ifdef BCD_BLANK_EN
         for (int i = DIGITS - 1; i >= 1; i--) begin
            if (leading_w && (result_d[i*DIGIT_W +: DIGIT_W] == 4'h0)) begin
               result_d[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
            end else begin
               leading_w = 1'b0;
            end
         end
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         sreg_q   <= '0;
         digits_q <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state_q  <= ST_SHIFT;
                  busy_q   <= 1'b1;
                  sreg_q   <= bus.data;
                  digits_q <= '0;
                  cnt_q    <= '0;
                  sticky_q <= 1'b0;
               end
            end
            ST_SHIFT: begin
               digits_q <= digits_d;
               sreg_q   <= sreg_d;
               sticky_q <= sticky_d;
               cnt_q    <= cnt_q + CNT_W'(1);
               // result publishes on the final shift edge, entering DONE
               if (cnt_q == LAST_CNT) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  bcd_q   <= result_d;
                  ovf_q   <= sticky_d;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.bcd      = bcd_q;
   assign bus.overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_binary_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_binary_to_bcd_seq : checks 8-bit and 10-bit converters against a decimal model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_binary_to_bcd_seq;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   binary_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) if8 ();
   binary_to_bcd_seq_if #(.WIDTH(10), .DIGITS(3)) if10 ();

   binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
      .clock (clock),
      .reset (reset),
      .bus   (if8)
   );

   binary_to_bcd_seq #(.WIDTH(10), .DIGITS(3)) u_dut10 (
      .clock (clock),
      .reset (reset),
      .bus   (if10)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          sel;
      int          val;
      logic [11:0] bcd;
      logic        ov;
   } vec_t;

   vec_t tab [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] tb_blank(input logic [11:0] b);
      logic [11:0] r;
      r = b;
`ifdef BCD_BLANK_EN
      if (r[11:8] == 4'h0) begin
         r[11:8] = 4'hF;
         if (r[7:4] == 4'h0) r[7:4] = 4'hF;
      end
`endif
      return r;
   endfunction

   // Decimal reference: {overflow, bcd}
   function automatic logic [12:0] model(input int v);
      logic [11:0] r;
      if (v > 999) return {1'b1, 12'h999};
      r[11:8] = 4'(v / 100);
      r[7:4]  = 4'((v / 10) % 10);
      r[3:0]  = 4'(v % 10);
      return {1'b0, tb_blank(r)};
   endfunction

   function automatic logic sig_done(input int sel);
      return (sel != 0) ? if10.done : if8.done;
   endfunction
   function automatic logic sig_busy(input int sel);
      return (sel != 0) ? if10.busy : if8.busy;
   endfunction
   function automatic logic [11:0] sig_bcd(input int sel);
      return (sel != 0) ? if10.bcd : if8.bcd;
   endfunction
   function automatic logic sig_ovf(input int sel);
      return (sel != 0) ? if10.overflow : if8.overflow;
   endfunction

   task automatic drive(input int sel, input logic s, input int v);
      if (sel != 0) begin
         if10.start = s;
         if10.data  = 10'(v);
      end else begin
         if8.start = s;
         if8.data  = 8'(v);
      end
   endtask

   // One conversion with a 1-cycle start; checks latency, busy length and result
   task automatic conv(input int sel, input int v, input logic [12:0] exp, input string name);
      int          w;
      int          lat;
      int          bc;
      logic [11:0] b;
      logic        o;
      w   = (sel != 0) ? 10 : 8;
      lat = 0;
      bc  = 0;
      @(negedge clock);
      drive(sel, 1'b1, v);
      @(negedge clock);
      drive(sel, 1'b0, int'($urandom));
      while (!sig_done(sel) && lat < 40) begin
         bc += int'(sig_busy(sel));
         @(negedge clock);
         lat++;
      end
      b  = sig_bcd(sel);
      o  = sig_ovf(sel);
      bc += int'(sig_busy(sel));
      check({name, " latency"}, lat, w);
      check({name, " bcd"}, b, exp[11:0]);
      check({name, " overflow"}, o, exp[12]);
      @(negedge clock);
      bc += int'(sig_busy(sel));
      check({name, " done_width"}, sig_done(sel), 1'b0);
      check({name, " busy_cycles"}, bc, w + 1);
   endtask

   initial begin
      int          k;
      int          d1;
      int          d2;
      int          nd;
      logic [11:0] b1;
      logic [11:0] b2;

      tab[0] = '{0, 237,  12'h237, 1'b0};
      tab[1] = '{0, 255,  12'h255, 1'b0};
      tab[2] = '{0, 0,    12'h000, 1'b0};
      tab[3] = '{0, 88,   12'h088, 1'b0};
      tab[4] = '{0, 88,   12'h088, 1'b0};
      tab[5] = '{1, 1023, 12'h999, 1'b1};
      tab[6] = '{1, 999,  12'h999, 1'b0};
      tab[7] = '{0, 9,    12'h009, 1'b0};
      tab[8] = '{1, 1000, 12'h999, 1'b1};
      tab[9] = '{1, 100,  12'h100, 1'b0};

      reset = 1'b1;
      drive(0, 1'b0, 0);
      drive(1, 1'b0, 0);
      repeat (3) @(negedge clock);
      check("reset busy",  if8.busy, 1'b0);
      check("reset done",  if8.done, 1'b0);
      check("reset bcd",   if8.bcd, 12'h000);
      check("reset ovf",   if8.overflow, 1'b0);
      check("reset bcd10", if10.bcd, 12'h000);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         conv(tab[i].sel, tab[i].val,
              {tab[i].ov, tab[i].ov ? tab[i].bcd : tb_blank(tab[i].bcd)},
              $sformatf("vec%0d", i));
      end

      // start held high: 255 then 0, back to back
      @(negedge clock);
      drive(0, 1'b1, 255);
      @(negedge clock);
      if8.data = 8'd0;
      k = 0; d1 = -1; d2 = -1; b1 = '0; b2 = '0;
      while (d2 < 0 && k < 60) begin
         if (if8.done) begin
            if (d1 < 0) begin d1 = k; b1 = if8.bcd; end
            else        begin d2 = k; b2 = if8.bcd; end
         end
         @(negedge clock);
         k++;
      end
      drive(0, 1'b0, 0);
      check("b2b first_latency", d1, 8);
      check("b2b spacing", d2 - d1, 10);
      check("b2b bcd255", b1, tb_blank(12'h255));
      check("b2b bcd0", b2, tb_blank(12'h000));
      @(negedge clock);
      check("b2b idle_after", if8.busy, 1'b0);

      // start pulses during SHIFT are ignored
      @(negedge clock);
      drive(0, 1'b1, 42);
      @(negedge clock);
      drive(0, 1'b0, 42);
      nd = 0; b1 = '0;
      for (int j = 0; j < 25; j++) begin
         if (if8.done) begin nd++; b1 = if8.bcd; end
         drive(0, (j == 3 || j == 6), (j == 3 || j == 6) ? 50 : 42);
         @(negedge clock);
      end
      check("ignore done_count", nd, 1);
      check("ignore bcd", b1, tb_blank(12'h042));

      // reset mid-conversion aborts without a done pulse
      @(negedge clock);
      drive(0, 1'b1, 199);
      @(negedge clock);
      drive(0, 1'b0, 0);
      nd = 0;
      for (int j = 0; j < 4; j++) begin
         nd += int'(if8.done);
         @(negedge clock);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort busy", if8.busy, 1'b0);
      check("abort bcd", if8.bcd, 12'h000);
      check("abort ovf", if8.overflow, 1'b0);
      for (int j = 0; j < 12; j++) begin
         nd += int'(if8.done);
         @(negedge clock);
      end
      check("abort no_done", nd, 0);
      conv(0, 199, model(199), "after_abort");

      for (int i = 0; i < 12; i++) begin
         k = int'($urandom_range(0, 255));
         conv(0, k, model(k), $sformatf("rnd8_%0d", k));
      end
      for (int i = 0; i < 12; i++) begin
         k = int'($urandom_range(0, 1023));
         conv(1, k, model(k), $sformatf("rnd10_%0d", k));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/binary_to_bcd_seq.md
# binary_to_bcd_seq

Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It replaces the fixed 8-bit, 3-digit, count-down converter and has a fixed latency independent of the input value. It adds a start/busy/done handshake, overflow detection and optional leading-zero blanking. It sits between the heart-rate/statistics datapath and the hex/seven-segment display drivers.

## Interface
- `WIDTH`, 8: binary input width in bits, ≥1.
- `DIGITS`, 3: number of BCD output digits, ≥1.
- `clock` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request a conversion of `data`; sampled only in IDLE.
- `data` input WIDTH: unsigned binary value; captured on the accepting edge only.
- `busy` output 1: high from the accepting edge until return to IDLE.
- `done` output 1: one-cycle pulse when `bcd`/`overflow` update.
- `bcd` output 4*DIGITS: result; digit 0 (ones) in bits [3:0]; held between conversions.
- `overflow` output 1: result of the last conversion exceeded 10^DIGITS−1; held with `bcd`.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT when `start`=1.
  - Load the shift register with `data`.
  - Clear the 4*DIGITS working digits, the bit counter and the sticky overflow flag.
- SHIFT: each cycle, in this order:
  - Add 3 to every working digit ≥5.
  - Shift {digits, shift register} left by one bit.
  - Set the sticky overflow flag if the bit leaving the top digit is 1.
  - After the WIDTH-th shift, go to DONE.
- DONE (one cycle):
  - `done`=1.
  - If the sticky flag is set, `overflow`=1 and every digit of `bcd` = 9.
  - Otherwise `bcd` = working digits and `overflow`=0.
  - Then go to IDLE.
- `start` in SHIFT or DONE is ignored; it is not queued.
- No change-of-value filter: every accepted `start` converts, including a repeat of the previous value.
- Arithmetic:
  - Working digits never exceed 9 after a shift.
  - The add-3 is 4-bit and never wraps.
  - Bit counter width is $clog2(WIDTH+1).
- `WIDTH` ≤ floor(DIGITS·log2(10)) guarantees `overflow` never asserts (default 8/3: max 255).

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `bcd`=0, `overflow`=0; internal registers 0.
- Accepting edge E0 (IDLE, `start`=1): `busy`=1 after E0.
- Shifts happen on edges E1..E(WIDTH).
- State DONE and `done`=1 are visible after edge E(WIDTH); `bcd`/`overflow` update on that same edge.
- After edge E(WIDTH+1): `done`=0, `busy`=0, IDLE.
- Latency from accepting edge to `done` is WIDTH cycles; minimum spacing between accepted starts is WIDTH+2 cycles.
- `start` held high continuously produces back-to-back conversions every WIDTH+2 cycles.
- `reset` in any state aborts the conversion: no `done` pulse, outputs return to reset values on that edge.
- `reset` and `start` on the same edge: reset wins.
- `data` may change any time after E0 without effect.

## Configuration
- `BCD_BLANK_EN` defined: on the DONE update, each leading zero digit of `bcd` is replaced by 4'hF (blank code), scanning from the most significant digit down.
  - Digit 0 is never blanked, so value 0 gives ...F0.
  - The overflow result (all 9s) has no zeros and is not affected.
- Undefined: leading zeros are output as 4'h0.
- Timing and latency are identical in both cases.

## Structure
- Shared package/header (`bcd_defs`):
  - Digit width constant (4).
  - Blank code 4'hF.
  - Saturation digit 4'h9.
  - State encodings IDLE/SHIFT/DONE.
- Sub-module `bcd_add3`: combinational 4-bit digit correction (in ≥5 ? in+3 : in).
  - Instantiated DIGITS times via generate.
- Everything else (FSM, counter, shift register, blanking) lives in the top module.

## Test plan
- WIDTH=8, DIGITS=3, data=237, 1-cycle `start`:
  - `done` exactly 8 cycles after the accepting edge, for 1 cycle.
  - `bcd`=12'h237, `overflow`=0, `busy` high for 9 cycles.
- data=255 then data=0, back-to-back with `start` held high:
  - 12'h255, then 12'h000 (12'hFF0 with `BCD_BLANK_EN`).
  - Starts accepted 10 cycles apart.
- WIDTH=10, DIGITS=3:
  - data=1023 → `overflow`=1, `bcd`=12'h999.
  - Then data=999 → `overflow`=0, `bcd`=12'h999.
- `start` pulsed with data=50 at cycles 3 and 6 after accepting data=42:
  - Single `done` with `bcd`=12'h042.
  - Cycle-6 pulse ignored; no second `done`.
- `reset` asserted 4 cycles into a conversion of 199:
  - No `done` pulse.
  - `busy`/`bcd`/`overflow`=0 after the reset edge.
  - Next conversion of 199 gives 12'h199.
- Same value converted twice (data=88):
  - Both starts produce a `done` pulse.
  - `bcd`=12'h088 (12'hF88 with `BCD_BLANK_EN`).
